if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/ack handshake,
//  buffers returned words and drives instr/PCPlusFour into the IF/ID register. Sits between imem and IF/ID.
//  Honours hazard-unit stall (IF/ID enable low) and branch/jump redirect (flush).
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  BUF_DEPTH   2              fetch-buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   reset, synchronous, active-high
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  word address of request; stable while imem_req high
//  imem_ack     in   1   imem_rdata valid this cycle; completes request
//  imem_rdata   in   32  fetched instruction
//  stall        in   1   1 = IF/ID not accepting (its en low); head entry held
//  redirect     in   1   taken branch/jump; flush and refetch
//  redirect_pc  in   32  target PC, sampled when redirect=1
//  instr        out  32  head instruction; 32'h0 (NOP) when empty
//  PCPlusFour   out  32  head PC+4; 32'h0 when empty
//  instr_valid  out  1   buffer non-empty
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, buffer empty, FSM=IDLE, imem_req=0, imem_addr=0, instr=0, PCPlusFour=0, instr_valid=0.
//  - FSM IDLE: if no redirect and (count + 0) < BUF_DEPTH -> imem_req=1, imem_addr=fetch_pc, go WAIT.
//  - WAIT: on imem_ack (no redirect): push {imem_rdata, fetch_pc+4}, fetch_pc+=4; if space remains after push, issue next
//    request next cycle (IDLE->WAIT), else IDLE. Ack in the first req cycle is legal.
//  - Issue rule counts the outstanding request: never issue when count + outstanding == BUF_DEPTH -> no overflow.
//  - Output: instr/PCPlusFour/instr_valid driven from registered head entry; pushed data visible one cycle after ack.
//  - Pop: instr_valid && !stall at posedge -> head advances. Push+pop same cycle allowed; count unchanged.
//  - stall=1: head and outputs held; fetching continues until buffer full.
//  - redirect=1 (highest priority): buffer flushed (count=0, outputs 0 next cycle), fetch_pc<=redirect_pc.
//      IDLE -> request redirect_pc next cycle (WAIT).
//      WAIT with no ack same cycle -> DROP: imem_req stays high at old addr until ack, data discarded, then IDLE.
//      WAIT with ack same cycle -> ack data discarded, go IDLE.
//      DROP + redirect -> stay DROP, fetch_pc updated to newest redirect_pc.
//  - redirect and stall together: redirect wins, flush happens.
//  - fetch_pc wraps 32'hFFFF_FFFC -> 0; PCPlusFour computed mod 2^32. redirect_pc[1:0] ignored (forced 00).
//  - Reset mid-transaction: all state cleared immediately; an ack arriving after reset is ignored (FSM IDLE).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles stall && instr_valid) and perf_drop_cnt[31:0]
//    (fetched words discarded by redirect, incl. DROP acks and flushed entries); both cleared by rst, wrap at 2^32.
//  Not defined: ports and counters absent; functional behaviour identical.
// TESTING
//  1. rst, RESET_PC=0, ack 1 cycle after each req, stall=0 -> imem_addr 0,4,8..; instr_valid rises, PCPlusFour 4,8,12.
//  2. Hold stall=1 from 2nd word, BUF_DEPTH=2 -> outputs hold PCPlusFour=8; imem_req drops once buffer full; release -> 8,12,16.
//  3. redirect, redirect_pc=0x100 while request to 0x8 outstanding, ack 3 cycles later -> 0x8 data discarded, next imem_addr=0x100,
//     first valid PCPlusFour=0x104; perf_drop_cnt increments (FETCH_PERF_EN).
//  4. redirect coincident with imem_ack -> acked word never appears on instr; next req addr=redirect_pc.
//  5. rst asserted in WAIT, ack next cycle -> no push, instr_valid=0, next req addr=RESET_PC.
//  6. redirect_pc=0xFFFF_FFFC -> PCPlusFour=0x0, following imem_addr=0x0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage between imem and the IF/ID register.
// Owns the fetch PC, issues one word request at a time over a req/ack
// handshake, and queues returned words in a small buffer. The head entry
// drives instr/PCPlusFour. The hazard unit can hold the head (stall) or
// flush everything and restart at a new PC (redirect).
// Optional feature macro: FETCH_PERF_EN adds the stall and drop counters.
//
// state | meaning
// IDLE  | no request outstanding; issue when the buffer has room or on redirect
// WAIT  | request outstanding; its returned word is pushed on ack
// DROP  | request outstanding but made stale by a redirect; its ack is discarded

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] PCPlusFour,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_pc4_q   [BUF_DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   target_pc;
  logic          unused_rpc_lo;

  // Targets are word aligned; the low two bits of redirect_pc are dropped.
  assign target_pc     = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // A redirect kills both the incoming word and any pop of the old stream.
  assign push = (state_q == S_WAIT) && imem_ack && !redirect;
  assign pop  = (count_q != '0) && !stall && !redirect;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign PCPlusFour  = instr_valid ? buf_pc4_q[rd_ptr_q] : 32'h0;
  assign imem_req    = (state_q != S_IDLE);
  assign imem_addr   = addr_q;

  // Fetch FSM next-state, fetch PC and request address.
  // IDLE only issues when nothing is outstanding, so count < depth is the
  // whole "count + outstanding" room check.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          addr_d     = target_pc;
          state_d    = S_WAIT;
        end else if (count_q < DEPTH_C) begin
          addr_d  = fetch_pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          state_d    = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        // Address stays on the old request until imem completes it.
        if (redirect) fetch_pc_d = target_pc;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer pointer and occupancy update; redirect empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc4_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] drop_inc;

  // Discarded words: flushed entries plus any ack that belongs to a stale request.
  always_comb begin
    drop_inc = 32'h0;
    if (redirect) drop_inc = 32'(count_q);
    if (imem_ack && ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect)))
      drop_inc = drop_inc + 32'd1;
  end

  // Performance counters, free running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0;
      perf_drop_cnt  <= 32'h0;
    end else begin
      if (stall && instr_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_drop_cnt <= perf_drop_cnt + drop_inc;
    end
  end
`endif

endmodule
